kl_decoder_1by2: RTL and testbench

- KLink address decoder/router that connects one uplink master port to two downlink slave ports.
- Requests are steered by address. Multi-beat write bursts are locked to their target port until the last beat.
- Responses from both slaves are merged onto the uplink with round-robin arbitration, locked per response burst.
- Sits below kl_arbiter_2by1, fanning the shared bus out to, e.g., memory (dn0) and MMIO (dn1).

---
 rtl/kl_if.sv | 31 +++
 rtl/kl_decoder_1by2.sv | 153 +++++++++++++++
 tb/tb_kl_decoder_1by2.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/kl_if.sv
// KLink channel bundle: request path (master to slave) and response path (slave to master).
interface kl_if;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic [2:0]  req_size;
    logic [4:0]  req_srcid;
    logic        req_valid;
    logic        req_ready;

    logic [63:0] resp_rdata;
    logic [2:0]  resp_size;
    logic [4:0]  resp_dstid;
    logic        resp_valid;
    logic        resp_ready;

    modport master (
        output req_addr, req_wen, req_wdata, req_wmask, req_size, req_srcid, req_valid,
        input  req_ready,
        input  resp_rdata, resp_size, resp_dstid, resp_valid,
        output resp_ready
    );

    modport slave (
        input  req_addr, req_wen, req_wdata, req_wmask, req_size, req_srcid, req_valid,
        output req_ready,
        output resp_rdata, resp_size, resp_dstid, resp_valid,
        input  resp_ready
    );
endinterface

// File: rtl/kl_decoder_1by2.sv
// KLink 1-to-2 address decoder: steers requests by address with write-burst locking,
// merges responses round-robin with per-burst locking. Zero-latency pass-through.
module kl_decoder_1by2 #(
    parameter logic [31:0] DN1_BASE        = 32'h8000_0000,
    parameter logic [31:0] DN1_MASK        = 32'hF000_0000,
    parameter int unsigned MAX_BURST_WIDTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    kl_if.slave    up,
    kl_if.master   dn0,
    kl_if.master   dn1
);
    localparam int unsigned CW = MAX_BURST_WIDTH + 1;

    typedef enum logic { REQ_IDLE, REQ_BURST } req_state_t;
    typedef enum logic { RSP_IDLE, RSP_BURST } rsp_state_t;

    // Beats per transfer: 64-bit beats, minimum one.
    function automatic logic [CW-1:0] beats(input logic [2:0] size);
        if (size <= 3'd3) return CW'(1);
        return CW'(1) << (size - 3'd3);
    endfunction

    // ---------------- request path ----------------
    req_state_t    req_state, req_state_nx;
    logic          req_sel, req_sel_nx;
    logic [CW-1:0] req_cnt, req_cnt_nx;
    logic          req_tgt;
    logic          req_hs;
    logic [CW-1:0] req_beats;
    logic          addr_hit1;

    assign addr_hit1 = (up.req_addr & DN1_MASK) == DN1_BASE;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_state <= REQ_IDLE;
            req_sel   <= 1'b0;
            req_cnt   <= '0;
        end else begin
            req_state <= req_state_nx;
            req_sel   <= req_sel_nx;
            req_cnt   <= req_cnt_nx;
        end
    end

    always_comb begin
        req_state_nx = req_state;
        req_sel_nx   = req_sel;
        req_cnt_nx   = req_cnt;
        req_tgt      = (req_state == REQ_BURST) ? req_sel : addr_hit1;
        req_hs       = up.req_valid & (req_tgt ? dn1.req_ready : dn0.req_ready);
        req_beats    = beats(up.req_size);
        case (req_state)
            REQ_IDLE: begin
                if (req_hs && up.req_wen && (req_beats > CW'(1))) begin
                    req_state_nx = REQ_BURST;
                    req_sel_nx   = req_tgt;
                    req_cnt_nx   = req_beats - CW'(1);
                end
            end
            REQ_BURST: begin
                if (req_hs) begin
                    req_cnt_nx = req_cnt - CW'(1);
                    if (req_cnt == CW'(1)) req_state_nx = REQ_IDLE;
                end
            end
        endcase
    end

    assign up.req_ready = req_hs;

    assign dn0.req_valid = up.req_valid & ~req_tgt;
    assign dn1.req_valid = up.req_valid &  req_tgt;

    // Payload fans out to both ports; only the selected valid qualifies it.
    assign dn0.req_addr  = up.req_addr;
    assign dn0.req_wen   = up.req_wen;
    assign dn0.req_wdata = up.req_wdata;
    assign dn0.req_wmask = up.req_wmask;
    assign dn0.req_size  = up.req_size;
    assign dn0.req_srcid = up.req_srcid;
    assign dn1.req_addr  = up.req_addr;
    assign dn1.req_wen   = up.req_wen;
    assign dn1.req_wdata = up.req_wdata;
    assign dn1.req_wmask = up.req_wmask;
    assign dn1.req_size  = up.req_size;
    assign dn1.req_srcid = up.req_srcid;

    // ---------------- response path ----------------
    rsp_state_t    rsp_state, rsp_state_nx;
    logic          rsp_sel, rsp_sel_nx;
    logic          prio, prio_nx;
    logic [CW-1:0] rsp_cnt, rsp_cnt_nx;
    logic          rsp_gnt;
    logic          rsp_hs;
    logic [CW-1:0] rsp_beats;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_state <= RSP_IDLE;
            rsp_sel   <= 1'b0;
            prio      <= 1'b0;
            rsp_cnt   <= '0;
        end else begin
            rsp_state <= rsp_state_nx;
            rsp_sel   <= rsp_sel_nx;
            prio      <= prio_nx;
            rsp_cnt   <= rsp_cnt_nx;
        end
    end

    always_comb begin
        rsp_state_nx = rsp_state;
        rsp_sel_nx   = rsp_sel;
        prio_nx      = prio;
        rsp_cnt_nx   = rsp_cnt;
        rsp_gnt      = 1'b0;
        case (rsp_state)
            RSP_IDLE:  rsp_gnt = (dn0.resp_valid & dn1.resp_valid) ? prio : dn1.resp_valid;
            RSP_BURST: rsp_gnt = rsp_sel;
        endcase
        rsp_hs    = (rsp_gnt ? dn1.resp_valid : dn0.resp_valid) & up.resp_ready;
        rsp_beats = beats(rsp_gnt ? dn1.resp_size : dn0.resp_size);
        case (rsp_state)
            RSP_IDLE: begin
                if (rsp_hs) begin
                    prio_nx = ~rsp_gnt;
                    if (rsp_beats > CW'(1)) begin
                        rsp_state_nx = RSP_BURST;
                        rsp_sel_nx   = rsp_gnt;
                        rsp_cnt_nx   = rsp_beats - CW'(1);
                    end
                end
            end
            RSP_BURST: begin
                if (rsp_hs) begin
                    rsp_cnt_nx = rsp_cnt - CW'(1);
                    if (rsp_cnt == CW'(1)) rsp_state_nx = RSP_IDLE;
                end
            end
        endcase
    end

    assign up.resp_valid  = rsp_gnt ? dn1.resp_valid : dn0.resp_valid;
    assign up.resp_rdata  = rsp_gnt ? dn1.resp_rdata : dn0.resp_rdata;
    assign up.resp_size   = rsp_gnt ? dn1.resp_size  : dn0.resp_size;
    assign up.resp_dstid  = rsp_gnt ? dn1.resp_dstid : dn0.resp_dstid;
    assign dn0.resp_ready = ~rsp_gnt & dn0.resp_valid & up.resp_ready;
    assign dn1.resp_ready =  rsp_gnt & dn1.resp_valid & up.resp_ready;

endmodule

// File: tb/tb_kl_decoder_1by2.sv
// Directed bench for kl_decoder_1by2 with a cycle-level routing/arbitration model.
module tb_kl_decoder_1by2;
    logic clk = 1'b0;
    logic rst;

    kl_if up();
    kl_if dn0();
    kl_if dn1();

    kl_decoder_1by2 dut (.clk(clk), .rst(rst), .up(up), .dn0(dn0), .dn1(dn1));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: remaining beats of an in-flight burst and the port it is locked to.
    int m_req_rem, m_req_port, m_prio, m_rsp_rem, m_rsp_port;

    int h0, h1, bad;
    logic [4:0] rdy_pat = 5'b11101;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        return ((a & 32'hF000_0000) == 32'h8000_0000) ? 1 : 0;
    endfunction

    function automatic int nbeats(input logic [2:0] s);
        int b;
        b = (1 << int'(s)) / 8;
        return (b < 1) ? 1 : b;
    endfunction

    // Per-cycle compare against the model, then advance the model on the handshakes it predicts.
    always @(negedge clk) begin : compare
        int tgt, g;
        logic ev0, ev1, erdy, euv, er0, er1;
        if (rst) begin
            m_req_rem = 0; m_req_port = 0; m_prio = 0; m_rsp_rem = 0; m_rsp_port = 0;
        end else begin
            tgt  = (m_req_rem > 0) ? m_req_port : decode(up.req_addr);
            ev0  = up.req_valid && (tgt == 0);
            ev1  = up.req_valid && (tgt == 1);
            erdy = up.req_valid && ((tgt == 1) ? dn1.req_ready : dn0.req_ready);
            check("dn0_req_valid", 64'(dn0.req_valid), 64'(ev0));
            check("dn1_req_valid", 64'(dn1.req_valid), 64'(ev1));
            check("up_req_ready",  64'(up.req_ready),  64'(erdy));
            if (ev0) begin
                check("dn0_req_addr",  64'(dn0.req_addr),  64'(up.req_addr));
                check("dn0_req_wdata", dn0.req_wdata, up.req_wdata);
                check("dn0_req_ctl", 64'({dn0.req_wen, dn0.req_wmask, dn0.req_size, dn0.req_srcid}),
                      64'({up.req_wen, up.req_wmask, up.req_size, up.req_srcid}));
            end
            if (ev1) begin
                check("dn1_req_addr",  64'(dn1.req_addr),  64'(up.req_addr));
                check("dn1_req_wdata", dn1.req_wdata, up.req_wdata);
                check("dn1_req_ctl", 64'({dn1.req_wen, dn1.req_wmask, dn1.req_size, dn1.req_srcid}),
                      64'({up.req_wen, up.req_wmask, up.req_size, up.req_srcid}));
            end

            if (m_rsp_rem > 0)                        g = m_rsp_port;
            else if (dn0.resp_valid && dn1.resp_valid) g = m_prio;
            else                                      g = dn1.resp_valid ? 1 : 0;
            euv = (g == 1) ? dn1.resp_valid : dn0.resp_valid;
            er0 = (g == 0) && dn0.resp_valid && up.resp_ready;
            er1 = (g == 1) && dn1.resp_valid && up.resp_ready;
            check("up_resp_valid", 64'(up.resp_valid),  64'(euv));
            check("dn0_resp_ready", 64'(dn0.resp_ready), 64'(er0));
            check("dn1_resp_ready", 64'(dn1.resp_ready), 64'(er1));
            if (euv) begin
                check("up_resp_rdata", up.resp_rdata, (g == 1) ? dn1.resp_rdata : dn0.resp_rdata);
                check("up_resp_ctl", 64'({up.resp_size, up.resp_dstid}),
                      (g == 1) ? 64'({dn1.resp_size, dn1.resp_dstid}) : 64'({dn0.resp_size, dn0.resp_dstid}));
            end

            if (erdy) begin
                if (m_req_rem > 0) m_req_rem--;
                else if (up.req_wen && nbeats(up.req_size) > 1) begin
                    m_req_port = tgt;
                    m_req_rem  = nbeats(up.req_size) - 1;
                end
            end
            if (euv && up.resp_ready) begin
                if (m_rsp_rem > 0) m_rsp_rem--;
                else begin
                    m_prio = 1 - g;
                    if (nbeats((g == 1) ? dn1.resp_size : dn0.resp_size) > 1) begin
                        m_rsp_port = g;
                        m_rsp_rem  = nbeats((g == 1) ? dn1.resp_size : dn0.resp_size) - 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic [31:0] a, input logic w, input logic [2:0] s,
                       input logic [63:0] d, input logic [4:0] id);
        up.req_valid = v; up.req_addr = a; up.req_wen = w; up.req_size = s;
        up.req_wdata = d; up.req_wmask = 8'hFF; up.req_srcid = id;
    endtask

    task automatic rsp0(input logic v, input logic [63:0] d, input logic [2:0] s, input logic [4:0] id);
        dn0.resp_valid = v; dn0.resp_rdata = d; dn0.resp_size = s; dn0.resp_dstid = id;
    endtask

    task automatic rsp1(input logic v, input logic [63:0] d, input logic [2:0] s, input logic [4:0] id);
        dn1.resp_valid = v; dn1.resp_rdata = d; dn1.resp_size = s; dn1.resp_dstid = id;
    endtask

    initial begin
        rst = 1'b1;
        req(0, 32'h0, 0, 3'd0, 64'h0, 5'd0);
        rsp0(0, 64'h0, 3'd0, 5'd0);
        rsp1(0, 64'h0, 3'd0, 5'd0);
        dn0.req_ready = 1'b1; dn1.req_ready = 1'b1; up.resp_ready = 1'b1;
        repeat (3) tick();
        #1;
        check("rst_up_resp_valid", 64'(up.resp_valid), 64'd0);
        check("rst_dn0_req_valid", 64'(dn0.req_valid), 64'd0);
        rst = 1'b0;
        tick();

        // Single-beat read to dn0, then its response straight through
        req(1, 32'h0000_1000, 0, 3'd3, 64'h0, 5'd2);
        #1;
        check("t1_dn0_req_valid", 64'(dn0.req_valid), 64'd1);
        check("t1_dn1_req_valid", 64'(dn1.req_valid), 64'd0);
        check("t1_up_req_ready",  64'(up.req_ready),  64'd1);
        tick();
        req(0, 32'h0, 0, 3'd0, 64'h0, 5'd0);
        rsp0(1, 64'hDEAD_BEEF, 3'd3, 5'd2);
        #1;
        check("t1_resp_valid", 64'(up.resp_valid), 64'd1);
        check("t1_resp_rdata", up.resp_rdata, 64'hDEAD_BEEF);
        check("t1_resp_dstid", 64'(up.resp_dstid), 64'd2);
        tick();
        rsp0(0, 64'h0, 3'd0, 5'd0);

        // Decode boundaries
        req(1, 32'h8000_0010, 0, 3'd3, 64'h0, 5'd7);
        #1;
        check("t2_hi_dn1", 64'(dn1.req_valid), 64'd1);
        check("t2_hi_dn0", 64'(dn0.req_valid), 64'd0);
        tick();
        req(1, 32'h7FFF_FFF8, 0, 3'd3, 64'h0, 5'd7);
        #1;
        check("t2_lo_dn0", 64'(dn0.req_valid), 64'd1);
        check("t2_lo_dn1", 64'(dn1.req_valid), 64'd0);
        tick();

        // 4-beat write burst to dn1; data beats carry addr 0 and must stay on dn1
        h0 = 0; h1 = 0;
        for (int i = 0; i < 5; i++) begin
            dn1.req_ready = rdy_pat[i];
            req(1, (h1 == 0) ? 32'h8000_0000 : 32'h0, 1, 3'd5, 64'h100 + 64'(h1), 5'd3);
            #1;
            if (dn0.req_valid && dn0.req_ready) h0++;
            if (dn1.req_valid && dn1.req_ready) h1++;
            tick();
        end
        dn1.req_ready = 1'b1;
        check("t3_dn1_beats", 64'(h1), 64'd4);
        check("t3_dn0_beats", 64'(h0), 64'd0);
        req(1, 32'h0, 0, 3'd3, 64'h0, 5'd4);
        #1;
        check("t3_after_dn0", 64'(dn0.req_valid), 64'd1);
        tick();
        req(0, 32'h0, 0, 3'd0, 64'h0, 5'd0);

        // Contention: a lone dn1 response first so prio points at dn0
        rsp1(1, 64'h11, 3'd3, 5'd1);
        tick();
        rsp1(0, 64'h0, 3'd0, 5'd0);
        rsp0(1, 64'hA0, 3'd3, 5'd1);
        rsp1(1, 64'hB0, 3'd3, 5'd1);
        #1;
        check("t4a_dn0_first", 64'(dn0.resp_ready), 64'd1);
        check("t4a_dn1_held",  64'(dn1.resp_ready), 64'd0);
        check("t4a_rdata",     up.resp_rdata, 64'hA0);
        tick();
        rsp0(0, 64'h0, 3'd0, 5'd0);
        #1;
        check("t4a_dn1_next", 64'(dn1.resp_ready), 64'd1);
        check("t4a_rdata2",   up.resp_rdata, 64'hB0);
        tick();
        rsp1(0, 64'h0, 3'd0, 5'd0);
        rsp0(1, 64'h22, 3'd3, 5'd1);
        tick();
        rsp0(1, 64'hA1, 3'd3, 5'd1);
        rsp1(1, 64'hB1, 3'd3, 5'd1);
        #1;
        check("t4b_dn1_first", 64'(dn1.resp_ready), 64'd1);
        check("t4b_dn0_held",  64'(dn0.resp_ready), 64'd0);
        tick();
        rsp1(0, 64'h0, 3'd0, 5'd0);
        #1;
        check("t4b_dn0_next", 64'(dn0.resp_ready), 64'd1);
        tick();
        rsp0(0, 64'h0, 3'd0, 5'd0);

        // 8-beat dn1 response burst with dn0 pending and uplink stalls; a read slips in meanwhile
        h1 = 0; bad = 0;
        rsp0(1, 64'hC0, 3'd3, 5'd6);
        for (int i = 0; i < 40 && h1 < 8; i++) begin
            rsp1(1, 64'h200 + 64'(h1), 3'd6, 5'd5);
            up.resp_ready = (i % 3) != 1;
            req(i == 2, 32'h0, 0, 3'd3, 64'h0, 5'd8);
            #1;
            if (dn0.resp_ready) bad++;
            if (dn1.resp_valid && dn1.resp_ready) h1++;
            tick();
        end
        req(0, 32'h0, 0, 3'd0, 64'h0, 5'd0);
        rsp1(0, 64'h0, 3'd0, 5'd0);
        up.resp_ready = 1'b1;
        #1;
        check("t5_dn1_beats", 64'(h1), 64'd8);
        check("t5_dn0_locked_out", 64'(bad), 64'd0);
        check("t5_dn0_after", 64'(dn0.resp_ready), 64'd1);
        check("t5_dn0_rdata", up.resp_rdata, 64'hC0);
        tick();
        rsp0(0, 64'h0, 3'd0, 5'd0);

        // Reset after beat 2 of a 4-beat write to dn1
        for (int i = 0; i < 2; i++) begin
            req(1, (i == 0) ? 32'h8000_0000 : 32'h0, 1, 3'd5, 64'h300 + 64'(i), 5'd3);
            tick();
        end
        req(0, 32'h0, 0, 3'd0, 64'h0, 5'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req(1, 32'h0, 0, 3'd3, 64'h0, 5'd9);
        #1;
        check("t6_dn0_after_rst", 64'(dn0.req_valid), 64'd1);
        check("t6_dn1_after_rst", 64'(dn1.req_valid), 64'd0);
        tick();
        req(0, 32'h0, 0, 3'd0, 64'h0, 5'd0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
